// File: rtl/circle_engine_if.sv
// ---------------------------------------------------------------------------
// circle_engine_if
//   Bundles the circle command interface from the graphics processor and
//   the DRAM request path (address FIFO + write-data FIFO) used by the
//   circle engine.
//
//   Command side : CE_ready, CE_color/_valid, CE_arguments/_valid,
//                  CE_trigger, CE_frame
//   DRAM side    : af_full, wdf_full (back-pressure in),
//                  af_wr_en, af_addr_din, wdf_wr_en, wdf_din, wdf_mask_din
//
//   master : the command issuer / FIFO owner (drives commands and fullness)
//   slave  : the circle engine itself
// ---------------------------------------------------------------------------
interface circle_engine_if;
    logic         CE_ready;
    logic [23:0]  CE_color;
    logic         CE_color_valid;
    logic [31:0]  CE_arguments;
    logic         CE_arguments_valid;
    logic         CE_trigger;
    logic [31:0]  CE_frame;
    logic         af_full;
    logic         wdf_full;
    logic         af_wr_en;
    logic [30:0]  af_addr_din;
    logic         wdf_wr_en;
    logic [127:0] wdf_din;
    logic [15:0]  wdf_mask_din;

    modport master (
        input  CE_ready, af_wr_en, af_addr_din, wdf_wr_en, wdf_din, wdf_mask_din,
        output CE_color, CE_color_valid, CE_arguments, CE_arguments_valid,
               CE_trigger, CE_frame, af_full, wdf_full
    );

    modport slave (
        output CE_ready, af_wr_en, af_addr_din, wdf_wr_en, wdf_din, wdf_mask_din,
        input  CE_color, CE_color_valid, CE_arguments, CE_arguments_valid,
               CE_trigger, CE_frame, af_full, wdf_full
    );
endinterface

// File: rtl/circle_engine.sv
// ---------------------------------------------------------------------------
// circle_engine
//   Rasterises a circle outline with the midpoint algorithm and issues one
//   masked single-pixel DRAM write (one address push, two data beats) per
//   plotted point into the frame buffer at CE_frame.
//
//   Ports:
//     clk  - clock
//     rst  - synchronous, active-high reset (aborts a draw immediately)
//     bus  - circle_engine_if.slave: command inputs, CE_ready, FIFO pushes
//
//   Parameters:
//     XRES / YRES - visible frame size; points outside are skipped.
//
//   Pixels are 32-bit words {8'h00, R, G, B}; rows are 4096 bytes apart
//   (x occupies address bits [11:2], y bits [21:12]). A 32-byte burst holds
//   eight pixels: beat 0 carries lanes 0-3, beat 1 lanes 4-7.
// ---------------------------------------------------------------------------
module circle_engine #(
    parameter int XRES = 800,
    parameter int YRES = 600
) (
    input  logic            clk,
    input  logic            rst,
    circle_engine_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, PLOT, BEAT1, STEP} state_t;

    state_t             state_reg, state_next;
    logic signed [10:0] x_reg, x_next;
    logic signed [10:0] y_reg, y_next;
    logic signed [11:0] err_reg, err_next;
    logic [2:0]         oct_reg, oct_next;
    logic [23:0]        color_reg, color_next;
    logic [31:0]        args_reg, args_next;

    logic               af_push;
    logic               wdf_push;
    logic               beat1_sel;

    // ---------------------------------------------------------------
    // Current point for the active octant (11-bit signed arithmetic)
    // ---------------------------------------------------------------
    logic signed [10:0] xc, yc;
    logic signed [10:0] px, py;
    logic               in_range;
    logic [31:0]        addr;
    logic [2:0]         lane;

    assign xc = $signed({1'b0, args_reg[29:20]});
    assign yc = $signed({1'b0, args_reg[19:10]});

    always_comb begin
        px = xc + x_reg;
        py = yc + y_reg;
        case (oct_reg)
            3'd0: begin px = xc + x_reg; py = yc + y_reg; end
            3'd1: begin px = xc + y_reg; py = yc + x_reg; end
            3'd2: begin px = xc - y_reg; py = yc + x_reg; end
            3'd3: begin px = xc - x_reg; py = yc + y_reg; end
            3'd4: begin px = xc - x_reg; py = yc - y_reg; end
            3'd5: begin px = xc - y_reg; py = yc - x_reg; end
            3'd6: begin px = xc + y_reg; py = yc - x_reg; end
            default: begin px = xc + x_reg; py = yc - y_reg; end
        endcase
    end

    // Sign bit set means the point fell off the left/top edge (or the sum
    // overflowed the 11-bit range); both are simply skipped.
    assign in_range = !px[10] && !py[10]
                   && ({22'b0, px[9:0]} < XRES)
                   && ({22'b0, py[9:0]} < YRES);

    assign addr = bus.CE_frame + {10'b0, py[9:0], px[9:0], 2'b00};
    assign lane = addr[4:2];

    // ---------------------------------------------------------------
    // Next-state / output logic
    // ---------------------------------------------------------------
    logic [9:0]         r_src;
    logic signed [11:0] x12, y12;

    // A trigger in the same cycle as an argument strobe uses the new radius.
    assign r_src = bus.CE_arguments_valid ? bus.CE_arguments[9:0] : args_reg[9:0];
    assign x12   = {x_reg[10], x_reg};
    assign y12   = {y_reg[10], y_reg};

    always_comb begin
        state_next = state_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        err_next   = err_reg;
        oct_next   = oct_reg;
        color_next = color_reg;
        args_next  = args_reg;
        af_push    = 1'b0;
        wdf_push   = 1'b0;
        beat1_sel  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.CE_color_valid)
                    color_next = bus.CE_color;
                if (bus.CE_arguments_valid)
                    args_next = bus.CE_arguments;
                if (bus.CE_trigger) begin
                    x_next     = $signed({1'b0, r_src});
                    y_next     = 11'sd0;
                    err_next   = 12'sd1 - $signed({2'b00, r_src});
                    oct_next   = 3'd0;
                    state_next = PLOT;
                end
            end

            PLOT: begin
                if (!in_range) begin
                    oct_next   = oct_reg + 3'd1;
                    state_next = (oct_reg == 3'd7) ? STEP : PLOT;
                end else if (!bus.af_full && !bus.wdf_full) begin
                    af_push    = 1'b1;
                    wdf_push   = 1'b1;
                    state_next = BEAT1;
                end
            end

            BEAT1: begin
                beat1_sel = 1'b1;
                if (!bus.wdf_full) begin
                    wdf_push   = 1'b1;
                    oct_next   = oct_reg + 3'd1;
                    state_next = (oct_reg == 3'd7) ? STEP : PLOT;
                end
            end

            default: begin // STEP
                y_next = y_reg + 11'sd1;
                if (err_reg < 0) begin
                    err_next = err_reg + (y12 <<< 1) + 12'sd3;
                end else begin
                    x_next   = x_reg - 11'sd1;
                    err_next = err_reg + ((y12 - x12) <<< 1) + 12'sd5;
                end
                oct_next   = 3'd0;
                state_next = (x_next < y_next) ? IDLE : PLOT;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            x_reg     <= '0;
            y_reg     <= '0;
            err_reg   <= '0;
            oct_reg   <= '0;
            color_reg <= '0;
            args_reg  <= '0;
        end else begin
            state_reg <= state_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            err_reg   <= err_next;
            oct_reg   <= oct_next;
            color_reg <= color_next;
            args_reg  <= args_next;
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    assign bus.CE_ready    = (state_reg == IDLE);
    assign bus.af_wr_en    = af_push;
    assign bus.wdf_wr_en   = wdf_push;
    assign bus.af_addr_din = af_push ? {addr[30:5], 5'b0} : 31'h0;

    // Only the lane holding the pixel, and only in the beat that carries
    // it, is unmasked; everything else (including idle cycles) stays masked.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic lane_hit;
            assign lane_hit = wdf_push && (lane[2] == beat1_sel)
                           && (lane[1:0] == 2'(gi));
            assign bus.wdf_mask_din[4*gi +: 4] = {4{~lane_hit}};
            assign bus.wdf_din[32*gi +: 32]    = wdf_push ? {8'h00, color_reg} : 32'h0;
        end
    endgenerate

endmodule

// File: tb/tb_circle_engine.sv
// ---------------------------------------------------------------------------
// tb_circle_engine
//   Drives circle commands into circle_engine and compares every FIFO push
//   against a reference list built from the midpoint circle rules with
//   plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_circle_engine;
    localparam int XRES   = 800;
    localparam int YRES   = 600;
    localparam int BUDGET = 5000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    circle_engine_if bus();

    circle_engine #(.XRES(XRES), .YRES(YRES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int illegal  = 0;
    bit bp_en    = 1'b0;

    logic [30:0]  got_af[$];
    logic [143:0] got_wd[$];
    logic [30:0]  exp_af[$];
    logic [143:0] exp_wd[$];

    // Capture pushes and protocol violations away from the active edge.
    always @(negedge clk) begin
        if (bus.af_wr_en) begin
            if (bus.af_full) illegal++;
            got_af.push_back(bus.af_addr_din);
        end
        if (bus.wdf_wr_en) begin
            if (bus.wdf_full) illegal++;
            got_wd.push_back({bus.wdf_din, bus.wdf_mask_din});
        end else if (bus.wdf_mask_din !== 16'hFFFF) begin
            illegal++;
        end
        if (bus.af_wr_en && !bus.wdf_wr_en) illegal++;
    end

    // Random back-pressure generator
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) begin
                bus.af_full  = ($urandom_range(0, 3) == 0);
                bus.wdf_full = ($urandom_range(0, 3) == 0);
            end
        end
    end

    task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pix_addr(input logic [31:0] frame, input int px, input int py);
        return frame + 32'(py * 4096 + px * 4);
    endfunction

    // Reference: enumerate midpoint points, octant by octant, clip, and
    // turn each visible point into one address push plus two data beats.
    task automatic build_expected(input logic [23:0] col, input int xc, input int yc,
                                  input int r, input logic [31:0] frame);
        int x, y, err, px, py, p;
        int dx[8], dy[8];
        logic [31:0]  a;
        logic [15:0]  m0, m1;
        logic [127:0] data;
        exp_af.delete();
        exp_wd.delete();
        data = {4{8'h00, col}};
        x = r; y = 0; err = 1 - r;
        while (x >= y) begin
            dx = '{x, y, -y, -x, -x, -y, y, x};
            dy = '{y, x, x, y, -y, -x, -x, -y};
            for (int o = 0; o < 8; o++) begin
                px = ((xc + dx[o] + 1024) & 2047) - 1024;
                py = ((yc + dy[o] + 1024) & 2047) - 1024;
                if (px < 0 || py < 0 || px >= XRES || py >= YRES) continue;
                a  = pix_addr(frame, px, py);
                p  = int'(a[4:2]);
                m0 = 16'hFFFF;
                m1 = 16'hFFFF;
                if (p < 4) m0 = ~(16'h000F << (4 * p));
                else       m1 = ~(16'h000F << (4 * (p - 4)));
                exp_af.push_back({a[30:5], 5'b0});
                exp_wd.push_back({data, m0});
                exp_wd.push_back({data, m1});
            end
            if (err < 0) begin
                err = err + 2 * y + 3;
            end else begin
                err = err + 2 * (y - x) + 5;
                x = x - 1;
            end
            y = y + 1;
        end
    endtask

    task automatic compare_all(input string tag);
        int n;
        check({tag, "_af_count"}, 144'(got_af.size()), 144'(exp_af.size()));
        check({tag, "_wd_count"}, 144'(got_wd.size()), 144'(exp_wd.size()));
        n = (got_af.size() < exp_af.size()) ? got_af.size() : exp_af.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_af%0d", tag, i), 144'(got_af[i]), 144'(exp_af[i]));
        n = (got_wd.size() < exp_wd.size()) ? got_wd.size() : exp_wd.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_wd%0d", tag, i), got_wd[i], exp_wd[i]);
        check({tag, "_illegal"}, 144'(illegal), 144'(0));
    endtask

    // mode: 0 plain, 1 busy disturbance, 2 af_full hold, 3 wdf_full hold,
    //       4 reset after third address push
    task automatic run_circle(input string tag, input logic [23:0] col, input bit set_col,
                              input int xc, input int yc, input int r,
                              input logic [31:0] frame, input int mode, input bit do_cmp);
        bit done = 0;
        int hold = 0;
        int base_af = 0, base_wd = 0;
        logic [1:0] junk;
        got_af.delete();
        got_wd.delete();
        illegal = 0;
        junk = 2'($urandom);
        @(posedge clk); #1;
        bus.CE_color           = col;
        bus.CE_color_valid     = set_col;
        bus.CE_arguments       = {junk, 10'(xc), 10'(yc), 10'(r)};
        bus.CE_arguments_valid = 1'b1;
        bus.CE_trigger         = 1'b1;
        bus.CE_frame           = frame;
        @(posedge clk); #1;
        bus.CE_color_valid     = 1'b0;
        bus.CE_arguments_valid = 1'b0;
        bus.CE_trigger         = 1'b0;
        @(negedge clk); #2;
        check({tag, "_ready_low"}, 144'(bus.CE_ready), 144'(0));
        for (int cnt = 0; cnt < BUDGET && !done; cnt++) begin
            if (mode == 1 && cnt == 3) begin
                bus.CE_trigger = 1'b1;
                bus.CE_color_valid = 1'b1;
                bus.CE_color = ~col;
                bus.CE_arguments_valid = 1'b1;
                bus.CE_arguments = $urandom;
            end
            if (mode == 1 && cnt == 4) begin
                bus.CE_trigger = 1'b0;
                bus.CE_color_valid = 1'b0;
                bus.CE_arguments_valid = 1'b0;
                bus.CE_color = col;
            end
            if (mode == 2) begin
                if (hold == 0 && got_af.size() == 2) begin
                    bus.af_full = 1'b1;
                    base_af = got_af.size();
                    hold = 1;
                end else if (hold > 0 && hold < 6) begin
                    hold++;
                    if (hold == 6) begin
                        check({tag, "_no_af_while_full"}, 144'(got_af.size()), 144'(base_af));
                        bus.af_full = 1'b0;
                    end
                end
            end
            if (mode == 3) begin
                if (hold == 0 && got_wd.size() == 1) begin
                    bus.wdf_full = 1'b1;
                    base_wd = got_wd.size();
                    hold = 1;
                end else if (hold > 0 && hold < 4) begin
                    hold++;
                    if (hold == 4) begin
                        check({tag, "_beat1_held"}, 144'(got_wd.size()), 144'(base_wd));
                        bus.wdf_full = 1'b0;
                    end
                end
            end
            if (mode == 4 && got_af.size() == 3) begin
                rst = 1'b1;
                @(negedge clk); #2;
                check({tag, "_rst_af_en"},  144'(bus.af_wr_en),  144'(0));
                check({tag, "_rst_wdf_en"}, 144'(bus.wdf_wr_en), 144'(0));
                check({tag, "_rst_ready"},  144'(bus.CE_ready),  144'(1));
                rst = 1'b0;
                base_af = got_af.size();
                repeat (6) @(negedge clk);
                #2;
                check({tag, "_rst_no_push"}, 144'(got_af.size()), 144'(base_af));
                return;
            end
            if (bus.CE_ready) done = 1;
            else begin
                @(negedge clk); #2;
            end
        end
        check({tag, "_finished"}, 144'(done), 144'(1));
        if (do_cmp) begin
            build_expected(col, xc, yc, r, frame);
            compare_all(tag);
        end
    endtask

    function automatic bit has_af(input logic [31:0] a);
        foreach (got_af[i]) if (got_af[i] == {a[30:5], 5'b0}) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        logic [23:0] col;
        logic [31:0] frame;
        bus.CE_color           = '0;
        bus.CE_color_valid     = 1'b0;
        bus.CE_arguments       = '0;
        bus.CE_arguments_valid = 1'b0;
        bus.CE_trigger         = 1'b0;
        bus.CE_frame           = '0;
        bus.af_full            = 1'b0;
        bus.wdf_full           = 1'b0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #2;
        check("reset_ready",  144'(bus.CE_ready),     144'(1));
        check("reset_af_en",  144'(bus.af_wr_en),     144'(0));
        check("reset_wdf_en", 144'(bus.wdf_wr_en),    144'(0));
        check("reset_addr",   144'(bus.af_addr_din),  144'(0));
        check("reset_data",   144'(bus.wdf_din),      144'(0));
        check("reset_mask",   144'(bus.wdf_mask_din), 144'(16'hFFFF));
        check("reset_idle_pushes", 144'(got_af.size() + got_wd.size()), 144'(0));

        // r = 0: centre written eight times, lane 4 -> beat 1 mask FFF0
        run_circle("r0", 24'h00FF00, 1'b1, 100, 100, 0, 32'h10400000, 0, 1'b1);
        check("r0_af_pushes",  144'(got_af.size()), 144'(8));
        check("r0_wd_pushes",  144'(got_wd.size()), 144'(16));
        if (got_wd.size() >= 2) begin
            check("r0_beat0_mask", 144'(got_wd[0][15:0]), 144'(16'hFFFF));
            check("r0_beat1_mask", 144'(got_wd[1][15:0]), 144'(16'hFFF0));
        end

        // r = 3 around (10,10)
        run_circle("r3", 24'h123456, 1'b1, 10, 10, 3, 32'h00000000, 0, 1'b1);
        check("r3_pt_13_10", 144'(has_af(pix_addr(0, 13, 10))), 144'(1));
        check("r3_pt_12_12", 144'(has_af(pix_addr(0, 12, 12))), 144'(1));

        // Clipping near the bottom-left corner
        run_circle("clip", 24'hABCDEF, 1'b1, 2, 598, 5, 32'h00200000, 0, 1'b1);
        check("clip_pt_7_598", 144'(has_af(pix_addr(32'h00200000, 7, 598))), 144'(1));
        check("clip_pt_2_593", 144'(has_af(pix_addr(32'h00200000, 2, 593))), 144'(1));

        // Back-pressure
        run_circle("af_bp",  24'h0F0F0F, 1'b1, 300, 200, 6, 32'h01000000, 2, 1'b1);
        run_circle("wdf_bp", 24'hF0F0F0, 1'b1, 400, 300, 4, 32'h01000004, 3, 1'b1);

        // Busy disturbance, then a circle relying on the latched colour
        run_circle("busy", 24'h5A5A5A, 1'b1, 50, 60, 7, 32'h02000000, 1, 1'b1);
        run_circle("keep_col", 24'h5A5A5A, 1'b0, 70, 80, 2, 32'h02000000, 0, 1'b1);

        // Reset mid-draw; the colour register is cleared, so the redraw uses 0
        run_circle("rst_mid", 24'h777777, 1'b1, 200, 200, 9, 32'h03000000, 4, 1'b0);
        run_circle("after_rst", 24'h000000, 1'b0, 200, 200, 9, 32'h03000000, 0, 1'b1);

        // Randomised circles with random back-pressure
        bp_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            col   = 24'($urandom);
            frame = $urandom;
            run_circle($sformatf("rnd%0d", k), col, 1'b1,
                       int'($urandom_range(0, 820)), int'($urandom_range(0, 620)),
                       int'($urandom_range(0, 40)), frame, 0, 1'b1);
        end
        bp_en = 1'b0;
        bus.af_full  = 1'b0;
        bus.wdf_full = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
